// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the issue-stage scoreboard:
// decoder bundle, memory command codes, fence FSM states.
package issue_scoreboard_pkg;

    typedef logic [4:0] mem_cmd_t;

    localparam mem_cmd_t M_XRD       = 5'b00000;
    localparam mem_cmd_t M_XWR       = 5'b00001;
    localparam mem_cmd_t M_FLUSH_ALL = 5'b00101;

    typedef struct packed {
        logic     legal;
        logic     rxs1;
        logic     rxs2;
        logic     wxd;
        logic     mem;
        mem_cmd_t mem_cmd;
        logic     div;
        logic     fence;
        logic     fence_i;
    } ControlSignals;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_DRAIN,
        FS_FLUSH,
        FS_DONE
    } fence_state_e;

    // Load or store that occupies a memory slot until its response.
    function automatic logic is_mem_op(input ControlSignals cs);
        return cs.mem && (cs.mem_cmd == M_XRD || cs.mem_cmd == M_XWR);
    endfunction

    // Op whose result arrives later on the long-latency writeback port.
    function automatic logic is_long_lat(input ControlSignals cs);
        return (cs.mem && cs.mem_cmd == M_XRD) || cs.div;
    endfunction

endpackage

// File: rtl/issue_scoreboard_regmask.sv
// Pending-write bitmap: one set port, one clear port, set wins.
// Ports: clk, rst_n, set_en/set_idx, clr_en/clr_idx, mask out.
module sb_regmask #(
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [4:0]       set_idx,
    input  logic             clr_en,
    input  logic [4:0]       clr_idx,
    output logic [NREGS-1:0] mask
);

    logic [NREGS-1:0] mask_q;
    logic [NREGS-1:0] mask_d;
    logic [NREGS-1:0] set_oh;
    logic [NREGS-1:0] clr_oh;

    // x0 is hardwired zero, so index 0 is never tracked
    always_comb begin
        set_oh = '0;
        clr_oh = '0;
        if (set_en && set_idx != 5'd0) set_oh[set_idx] = 1'b1;
        if (clr_en && clr_idx != 5'd0) clr_oh[clr_idx] = 1'b1;
        mask_d = (mask_q & ~clr_oh) | set_oh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mask_q <= '0;
        else        mask_q <= mask_d;
    end

    assign mask = mask_q;

endmodule

// File: rtl/issue_scoreboard.sv
// Issue interlock: RAW/WAW on long-latency dests, memory slot limit,
// FENCE/FENCE_I drain + I-cache flush sequencing.
// Ports: ID bundle in, kill/writeback/resp/flush_done in,
// id_stall/id_issue/icache_flush_req/busy_mask/mem_outstanding out.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int NREGS       = 32,
    parameter int MAX_MEM_OUT = 4,
    localparam int CW         = $clog2(MAX_MEM_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  ControlSignals    id_cs,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             ex_kill,
    input  logic             ll_wb_valid,
    input  logic [4:0]       ll_wb_rd,
    input  logic             mem_resp_valid,
    input  logic             icache_flush_done,
    output logic             id_stall,
    output logic             id_issue,
    output logic             icache_flush_req,
    output logic [NREGS-1:0] busy_mask,
    output logic [CW-1:0]    mem_outstanding
);

    logic [NREGS-1:0] wb_oh;
    logic [NREGS-1:0] busy_eff;
    logic             act;
    logic             raw;
    logic             waw;
    logic             memfull;
    logic             fence_hz;
    logic             set_en;
    logic             mem_inc;
    logic             drained;
    logic [CW-1:0]    mem_out_q;
    logic [CW-1:0]    mem_out_d;
    fence_state_e     state_q;
    fence_state_e     state_d;

    sb_regmask #(.NREGS(NREGS)) u_regmask (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (set_en),
        .set_idx (id_rd),
        .clr_en  (ll_wb_valid),
        .clr_idx (ll_wb_rd),
        .mask    (busy_mask)
    );

    // Hazards; a same-cycle writeback already satisfies the reader
    always_comb begin
        wb_oh = '0;
        if (ll_wb_valid) wb_oh[ll_wb_rd] = 1'b1;
        busy_eff = busy_mask & ~wb_oh;
        act      = id_valid & id_cs.legal;
        raw      = act & ((id_cs.rxs1 & busy_eff[id_rs1]) |
                          (id_cs.rxs2 & busy_eff[id_rs2]));
        waw      = act & id_cs.wxd & busy_eff[id_rd];
        memfull  = act & id_cs.mem & (id_cs.mem_cmd != M_FLUSH_ALL) &
                   (mem_out_q == CW'(MAX_MEM_OUT));
        fence_hz = act & (id_cs.fence | id_cs.fence_i) &
                   (state_q != FS_DONE);
        id_stall = id_valid & (raw | waw | memfull | fence_hz);
        id_issue = id_valid & ~id_stall & ~ex_kill;
        set_en   = id_issue & act & id_cs.wxd & is_long_lat(id_cs);
        mem_inc  = id_issue & act & is_mem_op(id_cs);
    end

    // Outstanding memory count; issue and response together cancel
    always_comb begin
        mem_out_d = mem_out_q;
        if (mem_inc && !mem_resp_valid)
            mem_out_d = mem_out_q + CW'(1);
        else if (!mem_inc && mem_resp_valid && mem_out_q != '0)
            mem_out_d = mem_out_q - CW'(1);
    end

    // Fence sequencer; only moves while the fence sits unkilled in ID
    always_comb begin
        state_d          = state_q;
        icache_flush_req = (state_q == FS_FLUSH);
        drained          = (mem_out_q == '0) && (busy_mask == '0);
        if (ex_kill) begin
            state_d = FS_IDLE;
        end else if (act && (id_cs.fence || id_cs.fence_i)) begin
            unique case (state_q)
                FS_IDLE:  state_d = FS_DRAIN;
                FS_DRAIN: if (drained)
                              state_d = id_cs.fence_i ? FS_FLUSH : FS_DONE;
                FS_FLUSH: if (icache_flush_done) state_d = FS_DONE;
                FS_DONE:  state_d = FS_IDLE;
                default:  state_d = FS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_out_q <= '0;
            state_q   <= FS_IDLE;
        end else begin
            mem_out_q <= mem_out_d;
            state_q   <= state_d;
        end
    end

    assign mem_outstanding = mem_out_q;

    // A response with nothing outstanding means a lost or duplicated op
    assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_resp_valid && !mem_inc && mem_out_q == '0));

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: per-cycle expectations queued
// at drive time and compared on the falling edge.
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    ControlSignals id_cs;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic          ex_kill, ll_wb_valid;
    logic [4:0]    ll_wb_rd;
    logic          mem_resp_valid, icache_flush_done;
    logic          id_stall, id_issue, icache_flush_req;
    logic [31:0]   busy_mask;
    logic [2:0]    mem_outstanding;

    issue_scoreboard dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id_valid          (id_valid),
        .id_cs             (id_cs),
        .id_rs1            (id_rs1),
        .id_rs2            (id_rs2),
        .id_rd             (id_rd),
        .ex_kill           (ex_kill),
        .ll_wb_valid       (ll_wb_valid),
        .ll_wb_rd          (ll_wb_rd),
        .mem_resp_valid    (mem_resp_valid),
        .icache_flush_done (icache_flush_done),
        .id_stall          (id_stall),
        .id_issue          (id_issue),
        .icache_flush_req  (icache_flush_req),
        .busy_mask         (busy_mask),
        .mem_outstanding   (mem_outstanding)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] id;
        logic        st;
        logic        is;
        logic        rq;
        logic [2:0]  cnt;
        logic [31:0] bm;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_bad = 0;
    int   step  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk($sformatf("s%0d stall", e.id), 32'(id_stall), 32'(e.st));
            chk($sformatf("s%0d issue", e.id), 32'(id_issue), 32'(e.is));
            chk($sformatf("s%0d freq", e.id),
                32'(icache_flush_req), 32'(e.rq));
            chk($sformatf("s%0d cnt", e.id),
                32'(mem_outstanding), 32'(e.cnt));
            chk($sformatf("s%0d busy", e.id), busy_mask, e.bm);
        end
    end

    function automatic ControlSignals mk(
        input logic r1, input logic r2, input logic w, input logic m,
        input mem_cmd_t c, input logic f, input logic fi);
        ControlSignals cs;
        cs         = '0;
        cs.legal   = 1'b1;
        cs.rxs1    = r1;
        cs.rxs2    = r2;
        cs.wxd     = w;
        cs.mem     = m;
        cs.mem_cmd = c;
        cs.fence   = f;
        cs.fence_i = fi;
        return cs;
    endfunction

    ControlSignals cs_lw, cs_sw, cs_add, cs_fence, cs_fencei, cs_ill;

    task automatic put(input ControlSignals cs, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd);
        id_valid = 1'b1;
        id_cs    = cs;
        id_rs1   = r1;
        id_rs2   = r2;
        id_rd    = rd;
    endtask

    task automatic idle();
        id_valid = 1'b0;
        id_cs    = '0;
        id_rs1   = '0;
        id_rs2   = '0;
        id_rd    = '0;
    endtask

    task automatic cyc(input logic st, input logic is, input logic rq,
                       input int cnt, input logic [31:0] bm);
        exp_t e;
        e.id  = 16'(step);
        e.st  = st;
        e.is  = is;
        e.rq  = rq;
        e.cnt = 3'(cnt);
        e.bm  = bm;
        step++;
        sb_q.push_back(e);
        @(negedge clk);
        @(posedge clk);
        #1;
        ex_kill           = 1'b0;
        ll_wb_valid       = 1'b0;
        ll_wb_rd          = '0;
        mem_resp_valid    = 1'b0;
        icache_flush_done = 1'b0;
    endtask

    localparam logic [31:0] B5 = 32'h20;

    initial begin
        cs_lw     = mk(1, 0, 1, 1, M_XRD, 0, 0);
        cs_sw     = mk(1, 1, 0, 1, M_XWR, 0, 0);
        cs_add    = mk(1, 1, 1, 0, M_XRD, 0, 0);
        cs_fence  = mk(0, 0, 0, 0, M_XRD, 1, 0);
        cs_fencei = mk(0, 0, 0, 0, M_XRD, 0, 1);
        cs_ill    = cs_lw;
        cs_ill.legal = 1'b0;

        rst_n = 1'b0;
        idle();
        ex_kill = 0; ll_wb_valid = 0; ll_wb_rd = 0;
        mem_resp_valid = 0; icache_flush_done = 0;
        #1;
        chk("rst stall", 32'(id_stall), 0);
        chk("rst issue", 32'(id_issue), 0);
        chk("rst freq", 32'(icache_flush_req), 0);
        chk("rst cnt", 32'(mem_outstanding), 0);
        chk("rst busy", busy_mask, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // RAW on load dest, released by same-cycle writeback
        put(cs_lw, 1, 0, 5);      cyc(0, 1, 0, 0, 0);
        put(cs_add, 5, 1, 6);     cyc(1, 0, 0, 1, B5);
        cyc(1, 0, 0, 1, B5);
        ll_wb_valid = 1; ll_wb_rd = 5;
        cyc(0, 1, 0, 1, B5);
        idle(); mem_resp_valid = 1;
        cyc(0, 0, 0, 1, 0);

        // WAW, then set beats same-cycle clear
        put(cs_lw, 1, 0, 5);      cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, B5);
        ll_wb_valid = 1; ll_wb_rd = 5;
        cyc(0, 1, 0, 1, B5);
        idle(); ll_wb_valid = 1; ll_wb_rd = 5; mem_resp_valid = 1;
        cyc(0, 0, 0, 2, B5);
        mem_resp_valid = 1;
        cyc(0, 0, 0, 1, 0);

        // memory slot limit, strict full
        for (int i = 0; i < 4; i++) begin
            put(cs_sw, 1, 2, 0);  cyc(0, 1, 0, i, 0);
        end
        cyc(1, 0, 0, 4, 0);
        mem_resp_valid = 1;
        cyc(1, 0, 0, 4, 0);
        cyc(0, 1, 0, 3, 0);
        idle();
        for (int i = 4; i > 0; i--) begin
            mem_resp_valid = 1;   cyc(0, 0, 0, i, 0);
        end

        // FENCE_I: drain, flush, issue
        put(cs_sw, 1, 2, 0);      cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 0);
        put(cs_fencei, 0, 0, 0);  cyc(1, 0, 0, 2, 0);
        mem_resp_valid = 1;       cyc(1, 0, 0, 2, 0);
        mem_resp_valid = 1;       cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        icache_flush_done = 1;    cyc(1, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        idle();                   cyc(0, 0, 0, 0, 0);

        // kill in DRAIN, then minimum-latency FENCE
        put(cs_sw, 1, 2, 0);      cyc(0, 1, 0, 0, 0);
        put(cs_fence, 0, 0, 0);   cyc(1, 0, 0, 1, 0);
        ex_kill = 1;              cyc(1, 0, 0, 1, 0);
        idle(); mem_resp_valid = 1;
        cyc(0, 0, 0, 1, 0);
        put(cs_fence, 0, 0, 0);   cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        idle();                   cyc(0, 0, 0, 0, 0);

        // x0 dest, wb to x0, illegal ops
        put(cs_lw, 1, 0, 0);      cyc(0, 1, 0, 0, 0);
        idle(); ll_wb_valid = 1; ll_wb_rd = 0;
        cyc(0, 0, 0, 1, 0);
        put(cs_ill, 1, 0, 9);     cyc(0, 1, 0, 1, 0);
        cs_ill = cs_fence; cs_ill.legal = 1'b0;
        put(cs_ill, 0, 0, 0);     cyc(0, 1, 0, 1, 0);
        idle(); mem_resp_valid = 1;
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);

        // async reset while flushing with a busy dest
        put(cs_fencei, 0, 0, 0);  cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        put(cs_lw, 1, 0, 5);      cyc(0, 1, 1, 0, 0);
        idle();                   cyc(0, 0, 1, 1, B5);
        #2 rst_n = 1'b0;
        #1;
        chk("ar stall", 32'(id_stall), 0);
        chk("ar issue", 32'(id_issue), 0);
        chk("ar freq", 32'(icache_flush_req), 0);
        chk("ar cnt", 32'(mem_outstanding), 0);
        chk("ar busy", busy_mask, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        put(cs_add, 5, 1, 6);     cyc(0, 1, 0, 0, 0);
        idle();                   cyc(0, 0, 0, 0, 0);

        chk("sb empty", 32'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
